// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with a start/done handshake.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] r;
  logic             borrow;
  logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  logic             d_c;
  logic             borrow_next_c;
  logic [WIDTH-1:0] r_next_c;

  // Full-subtractor cell on the current LSBs
  assign d_c           = sa[0] ^ sb[0] ^ borrow;
  assign borrow_next_c = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
  assign r_next_c      = {d_c, r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      r      <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          r      <= r_next_c[WIDTH-1:1];
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= borrow_next_c;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff  <= r_next_c;
            b_out <= borrow_next_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_msb != b_msb) && (d_c != a_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
  logic         prev_ovf;
`endif

  int unsigned  n_vec;
  int unsigned  n_err;
  logic [W-1:0] prev_diff;
  logic         prev_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, "_diff"}, 32'(diff), 32'(prev_diff));
    check({tag, "_bout"}, 32'(b_out), 32'(prev_bout));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(prev_ovf));
`endif
  endtask

  // Assumes start/a/b for this operation are already driven before the next posedge.
  task automatic accept_and_run(input logic [W-1:0] ea, input logic [W-1:0] eb,
                                input int disturb, input bit chain,
                                input logic [W-1:0] ca, input logic [W-1:0] cb);
    logic [W-1:0] ed;
    logic         ebo;
    ed  = ea - eb;
    ebo = (ea < eb);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check("busy_accept", 32'(busy), 32'd1);
    check("done_accept", 32'(done), 32'd0);
    for (int c = 1; c <= int'(W); c++) begin
      if (c == disturb) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
      end
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (c < int'(W)) begin
        check("busy_run", 32'(busy), 32'd1);
        check("done_run", 32'(done), 32'd0);
        check_held("held_run");
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("diff", 32'(diff), 32'(ed));
        check("b_out", 32'(b_out), 32'(ebo));
        prev_diff = ed;
        prev_bout = ebo;
`ifdef SERIAL_SUB_OVF_EN
        prev_ovf = (ea[W-1] != eb[W-1]) && (ed[W-1] != ea[W-1]);
        check("ovf", 32'(ovf), 32'(prev_ovf));
`endif
        if (chain) begin
          start = 1'b1;
          a = ca;
          b = cb;
        end
      end
    end
    if (!chain) begin
      @(posedge clk); @(negedge clk);
      check("done_drop", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check_held("held_idle");
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int disturb);
    start = 1'b1;
    a = av;
    b = bv;
    accept_and_run(av, bv, disturb, 1'b0, '0, '0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    prev_diff = '0;
    prev_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    prev_ovf = 1'b0;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_held("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op(8'h5A, 8'h3C, 0);
    run_op(8'h10, 8'h20, 0);
    run_op(8'h00, 8'h01, 0);
    run_op(8'hA5, 8'hA5, 0);
    run_op(8'h80, 8'h01, 0);
    run_op(8'h05, 8'h03, 0);
    run_op(8'hFF, 8'h00, 0);
    run_op(8'h00, 8'hFF, 0);

    // start during SHIFT is ignored
    run_op(8'h07, 8'h03, 3);

    // Back-to-back: second op accepted in the DONE cycle
    start = 1'b1;
    a = 8'h33;
    b = 8'h11;
    accept_and_run(8'h33, 8'h11, 0, 1'b1, 8'h09, 8'h02);
    accept_and_run(8'h09, 8'h02, 0, 1'b0, '0, '0);

    // Asynchronous reset mid-operation
    start = 1'b1;
    a = 8'hC3;
    b = 8'h42;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    prev_diff = '0;
    prev_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    prev_ovf = 1'b0;
`endif
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_held("abort");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(posedge clk); @(negedge clk);
      check("post_abort_done", 32'(done), 32'd0);
      check("post_abort_busy", 32'(busy), 32'd0);
    end
    run_op(8'h64, 8'h19, 0);

    // Randomized operations with occasional ignored starts and chaining
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb, rc, rd;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rc = W'($urandom);
        rd = W'($urandom);
        start = 1'b1;
        a = ra;
        b = rb;
        accept_and_run(ra, rb, 0, 1'b1, rc, rd);
        accept_and_run(rc, rd, 0, 1'b0, '0, '0);
      end else begin
        run_op(ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W)) : 0);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check_held("idle_gap");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing A - B, LSB first.
- One full-subtractor cell per clock, plus a borrow flop; the subtract counterpart of the team's combinational full adder.
- Trades latency (WIDTH cycles) for area.
- Serves small datapaths and lab controllers that need a start/done operation rather than a wide ripple subtractor.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk edge when not busy
a  input  WIDTH  minuend; captured when start is accepted
b  input  WIDTH  subtrahend; captured when start is accepted
busy  output  1  high while the subtraction is in progress
done  output  1  one-cycle pulse: result valid
diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next accepted start
b_out  output  1  final borrow (1 when a < b unsigned); held with diff

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, diff=0, b_out=0; internal shift registers, borrow and counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge -> capture a into shift reg SA and b into SB; borrow<=0; cnt<=0; busy<=1; go to SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT, per edge:
  - Bit cell: d = SA[0]^SB[0]^borrow; borrow_next = (~SA[0]&SB[0]) | (~(SA[0]^SB[0])&borrow).
  - Shift d into result reg R from the MSB side; shift SA and SB right by 1; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: diff<=final R, b_out<=borrow_next, busy<=0, done<=1; go to DONE.
- DONE: held for exactly one cycle.
  - done=1 during this cycle; it returns to 0 on the next edge.
  - start=1 here is accepted (back-to-back) exactly as in IDLE; otherwise go to IDLE.
- Latency:
  - start accepted at edge k.
  - WIDTH shift edges k+1..k+WIDTH.
  - done high in the cycle after edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored; operands are not re-captured and the running result is unaffected.
- Changes on a/b after capture have no effect.
- diff and b_out change only on the completing edge or on reset. They are not cleared by a new start until that operation completes.
- Counter is clog2(WIDTH) bits wide. No wrap beyond WIDTH-1 is reachable.
- Reset mid-operation aborts immediately; no done pulse is produced for the aborted operation.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, reset 0), updated on the same edge as diff.
  - ovf = signed two's-complement overflow = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operands.
- Undefined: no ovf port and no associated logic; all other behaviour identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start pulse -> busy high 8 cycles; done 1 cycle; diff=0x1E, b_out=0; done exactly 9 cycles after the start edge.
- a=0x10, b=0x20 -> diff=0xF0, b_out=1; a=0x00, b=0x01 -> diff=0xFF, b_out=1; a=b=0xA5 -> diff=0x00, b_out=0.
- Start with a=0x07, b=0x03; at cycle 3 drive start with a=0xFF, b=0x00 -> second request ignored; diff=0x04; exactly one done pulse.
- Back-to-back: start held high through DONE with a=0x09, b=0x02 -> second op accepted in the DONE cycle; diff=0x07 after a further 9 cycles; busy low only during the DONE cycle.
- Assert rst_n low at cycle 4 of an operation -> busy, done, diff, b_out all 0 immediately (no clock needed); no done after release; a new start then completes normally.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x05, b=0x03 -> ovf=0. Without the macro the bench compiles with no ovf port.
